// File: rtl/async_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | async_fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                               wr_clk,
  input  logic                               rst,
  input  logic                               arb_en,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic                               fifo_full,
  output logic                               fifo_wr_en,
  output logic [DATA_WIDTH+$clog2(NUM_REQ):0] fifo_wr_data,
  output logic                               busy,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] C_BEAT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  C_ID_MAX    = ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  int                cand;

  logic                  grant_valid;
  logic                  grant_last;
  logic [DATA_WIDTH-1:0] grant_data;

  // First valid requester at or above the rotating pointer, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[ID_W'(cand)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(cand);
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    grant_data  = '0;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        grant_valid  = req_valid[i];
        grant_last   = req_last[i];
        grant_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = busy & ~fifo_full;
      end
    end
  end

  assign busy         = (state_q == ST_BUSY);
  assign fifo_wr_en   = busy & grant_valid & ~fifo_full;
  assign fifo_wr_data = {grant_last, grant_q, grant_data};
  assign grant_id     = grant_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_found) begin
          grant_d = pick_id;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A full FIFO blocks fifo_wr_en, so the burst simply freezes here.
        if (fifo_wr_en) begin
          if (grant_last || (beat_cnt_q == C_BEAT_LAST)) begin
            state_d    = ST_IDLE;
            rr_d       = (grant_q == C_ID_MAX) ? '0 : grant_q + ID_W'(1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_async_fifo_wr_arbiter: vector table plus per-id scoreboard sequences    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_async_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int IW = 2;
  localparam int WW = DW + IW + 1;

  logic              wr_clk = 1'b0;
  logic              rst;
  logic              arb_en;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [WW-1:0]     fifo_wr_data;
  logic              busy;
  logic [IW-1:0]     grant_id;

  always #6.25 wr_clk = ~wr_clk;

  async_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .rst(rst), .arb_en(arb_en), .req_valid(req_valid),
    .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic [NR-1:0] mask;
    logic [IW-1:0] g;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vecs[10];

  int checks = 0;
  int errors = 0;
  logic [DW:0]   src_q [NR][$];
  logic [WW-1:0] exp_q [NR][$];
  int log_id[$];
  int log_last[$];
  int log_cyc[$];
  int cyc = 0;
  int wr_cnt = 0;
  logic full_n = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += src_q[i].size();
    return s;
  endfunction

  function automatic int exp_left();
    int s = 0;
    for (int i = 0; i < NR; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic add_pkt(int id, int len, logic [DW-1:0] base);
    for (int k = 0; k < len; k++) begin
      logic [DW-1:0] d;
      logic          l;
      d = base + DW'(k);
      l = (k == len - 1);
      src_q[id].push_back({l, d});
      exp_q[id].push_back({l, IW'(id), d});
    end
  endtask

  task automatic clear_logs();
    log_id.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic flush_all();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  // One clock: drive sources from queue heads, check outputs, pop accepted beats.
  task automatic cycle();
    logic [NR-1:0] acc;
    @(negedge wr_clk);
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = src_q[i][0][DW];
        req_data[i*DW +: DW] = src_q[i][0][DW-1:0];
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
    fifo_full = full_n;
    #1;
    acc = req_valid & req_ready;
    if (fifo_full) begin
      chk("wr_en_while_full", 32'(fifo_wr_en), 0);
      chk("ready_while_full", 32'(req_ready), 0);
    end
    if (fifo_wr_en) begin
      int id;
      id = int'(fifo_wr_data[DW +: IW]);
      chk("ready_matches_id", 32'(req_ready), 32'(1) << id);
      if (exp_q[id].size() == 0) chk("sb_underflow", 0, 1);
      else chk("sb_word", 32'(fifo_wr_data), 32'(exp_q[id].pop_front()));
      log_id.push_back(id);
      log_last.push_back(int'(fifo_wr_data[WW-1]));
      log_cyc.push_back(cyc);
      wr_cnt++;
    end
    @(posedge wr_clk);
    for (int i = 0; i < NR; i++) if (acc[i]) void'(src_q[i].pop_front());
    cyc++;
    #1;
  endtask

  task automatic run(int budget, int stall_at, int stall_len, int drop_at, bit rnd_full);
    int n = 0;
    int stall_left = stall_len;
    int start = wr_cnt;
    while ((pending() > 0 || busy) && n < budget) begin
      if (rnd_full) full_n = ($urandom_range(0, 4) == 0);
      else if (wr_cnt - start == stall_at && stall_left > 0) begin
        full_n = 1'b1;
        stall_left--;
      end else full_n = 1'b0;
      if (wr_cnt - start == drop_at) arb_en = 1'b0;
      cycle();
      n++;
    end
    full_n = 1'b0;
    chk("run_within_budget", 32'(n < budget), 1);
  endtask

  task automatic do_reset();
    flush_all();
    @(negedge wr_clk);
    rst = 1'b1; arb_en = 1'b0; full_n = 1'b0; fifo_full = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    repeat (2) @(negedge wr_clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_ready", 32'(req_ready), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    int n;
    rst = 1'b1; arb_en = 1'b0; fifo_full = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;

    // Round-robin vectors; each row depends on the pointer left by the previous one.
    vecs[0] = '{4'b1111, 2'd0, 8'h11};
    vecs[1] = '{4'b1111, 2'd1, 8'h22};
    vecs[2] = '{4'b1001, 2'd3, 8'h33};
    vecs[3] = '{4'b1001, 2'd0, 8'h44};
    vecs[4] = '{4'b1001, 2'd3, 8'h55};
    vecs[5] = '{4'b1001, 2'd0, 8'h66};
    vecs[6] = '{4'b0100, 2'd2, 8'h77};
    vecs[7] = '{4'b0010, 2'd1, 8'h88};
    vecs[8] = '{4'b0011, 2'd0, 8'h99};
    vecs[9] = '{4'b1000, 2'd3, 8'hAA};

    do_reset();
    for (int v = 0; v < 10; v++) begin
      @(negedge wr_clk);
      arb_en = 1'b1; fifo_full = 1'b0; req_valid = vecs[v].mask; req_last = '1;
      for (int j = 0; j < NR; j++) req_data[j*DW +: DW] = vecs[v].data ^ DW'(j);
      #1;
      chk("t_idle_wr_en", 32'(fifo_wr_en), 0);
      chk("t_idle_ready", 32'(req_ready), 0);
      @(negedge wr_clk); #1;
      chk("t_busy", 32'(busy), 1);
      chk("t_grant", 32'(grant_id), 32'(vecs[v].g));
      chk("t_ready", 32'(req_ready), 32'(1) << vecs[v].g);
      chk("t_wr_en", 32'(fifo_wr_en), 1);
      chk("t_word", 32'(fifo_wr_data), 32'({1'b1, vecs[v].g, vecs[v].data ^ DW'(vecs[v].g)}));
      @(negedge wr_clk);
      req_valid = '0;
      #1;
      chk("t_release", 32'(busy), 0);
      chk("t_grant_hold", 32'(grant_id), 32'(vecs[v].g));
    end

    // All four requesters, 3-beat packets.
    do_reset();
    arb_en = 1'b1; clear_logs();
    for (int i = 0; i < NR; i++) add_pkt(i, 3, 8'(8'h20 * i));
    run(200, -1, 0, -1, 1'b0);
    chk("c_count", 32'(log_id.size()), 12);
    for (int k = 0; k < 12 && k < log_id.size(); k++) begin
      chk("c_id", 32'(log_id[k]), 32'(k / 3));
      chk("c_last", 32'(log_last[k]), 32'(k % 3 == 2));
      if (k > 0) chk("c_gap", 32'(log_cyc[k] - log_cyc[k-1]), (k % 3 == 0) ? 2 : 1);
    end

    // 40-beat packet from requester 2: forced releases after 16 and 32 beats.
    clear_logs();
    add_pkt(2, 40, 8'h00);
    run(300, -1, 0, -1, 1'b0);
    chk("d_count", 32'(log_id.size()), 40);
    for (int k = 0; k < 40 && k < log_id.size(); k++) begin
      chk("d_id", 32'(log_id[k]), 2);
      chk("d_last", 32'(log_last[k]), 32'(k == 39));
      if (k > 0) chk("d_gap", 32'(log_cyc[k] - log_cyc[k-1]), (k == 16 || k == 32) ? 2 : 1);
    end

    // FIFO full for 5 cycles after the third beat of requester 1.
    clear_logs();
    add_pkt(1, 8, 8'hC0);
    run(100, 3, 5, -1, 1'b0);
    chk("e_count", 32'(log_id.size()), 8);
    if (log_cyc.size() == 8) chk("e_stall_gap", 32'(log_cyc[3] - log_cyc[2]), 6);

    // arb_en dropped mid-burst: burst finishes, no new grant until re-enabled.
    clear_logs();
    add_pkt(1, 6, 8'h60);
    run(100, -1, 0, 2, 1'b0);
    chk("f_count", 32'(log_id.size()), 6);
    chk("f_busy_fell", 32'(busy), 0);
    add_pkt(0, 3, 8'h70);
    start = wr_cnt;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("f_no_grant", 32'(busy), 0);
    end
    chk("f_no_writes", 32'(wr_cnt - start), 0);
    arb_en = 1'b1;
    run(100, -1, 0, -1, 1'b0);
    chk("f_after_enable", 32'(wr_cnt - start), 3);

    // Reset during beat 2 of a 5-beat burst.
    do_reset();
    arb_en = 1'b1;
    add_pkt(0, 5, 8'h50);
    start = wr_cnt;
    n = 0;
    while (wr_cnt - start < 1 && n < 20) begin
      cycle();
      n++;
    end
    rst = 1'b1;
    cycle();
    chk("g_beat2_written", 32'(wr_cnt - start), 2);
    @(negedge wr_clk); #1;
    chk("g_busy", 32'(busy), 0);
    chk("g_wr_en", 32'(fifo_wr_en), 0);
    chk("g_ready", 32'(req_ready), 0);
    chk("g_grant_id", 32'(grant_id), 0);
    flush_all();
    rst = 1'b0;
    req_valid = '0;

    // 1000 random packets with random back-pressure.
    for (int p = 0; p < 1000; p++)
      add_pkt($urandom_range(0, NR-1), $urandom_range(1, 8), 8'($urandom));
    run(60000, -1, 0, -1, 1'b1);
    chk("rand_sb_drained", 32'(exp_left()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
Shares the single write port of an async_fifo_fwft instance among NUM_REQ requesters in the wr_clk domain. Each requester presents beats on a valid/ready interface. The arbiter grants one requester at a time in round-robin order and holds the grant for a burst. It tags each written word with {last, source id} so the read side can demultiplex, and it obeys the FIFO's full flag so no beat is lost or duplicated.

Parameters:
NUM_REQ, 4, number of requesters (2..16); ID_W = $clog2(NUM_REQ) is a derived localparam
DATA_WIDTH, 8, payload width per beat
MAX_BURST, 16, maximum beats per grant before a forced release (1..256)

Ports:
wr_clk  in  1  write-domain clock, same clock as the FIFO write side
rst  in  1  reset, synchronous, active-high
arb_en  in  1  arbitration enable; when low, no new grant is issued
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester end-of-packet marker, qualified by valid
req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester beat accepted this cycle when valid&ready
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  DATA_WIDTH+ID_W+1  word to FIFO, packed {last, id, data}
busy  out  1  a grant is held
grant_id  out  ID_W  current or most recent grantee

Behaviour:
- Reset: state IDLE, busy=0, grant_id=0, rr pointer=0, beat_cnt=0. req_ready=0 and fifo_wr_en=0 combinationally, because state is IDLE.
- Asserting rst mid-burst abandons the burst; all outputs return to reset values the cycle after rst is sampled. No further beats are written.
- IDLE:
  - If arb_en=1 and any req_valid is set, select the first set bit searching upward from the rr pointer, with modulo-NUM_REQ wrap.
  - Register grant_id and go to BUSY (busy=1 on the next edge). The arbitration decision costs one dead cycle.
  - Otherwise remain in IDLE.
- BUSY:
  - req_ready[grant_id] = ~fifo_full. All other ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & ~fifo_full; fifo_wr_data = {req_last[g], g, req_data[g]}.
  - Both outputs are combinational, with zero latency from input to FIFO.
- Beat accept (fifo_wr_en=1):
  - beat_cnt increments.
  - If req_last[g]=1 or beat_cnt==MAX_BURST-1: go to IDLE, rr pointer ← g+1 (wrap), beat_cnt ← 0.
- Forced release at MAX_BURST is written with the original last bit (0). The requester re-arbitrates for the remainder of its packet; the id tag lets the reader reassemble it.
- If the granted requester drops valid mid-burst, the grant is held; there is no timeout.
- fifo_full=1 stalls the burst. The grant, beat_cnt and data are untouched, and fifo_wr_en never asserts while full=1.
- arb_en affects only IDLE→BUSY. Deassertion during BUSY lets the current burst complete.
- Simultaneous requests: the strict rotation guarantees each valid requester a grant within NUM_REQ grants.
- Non-granted requesters must hold valid/data stable; the arbiter never samples them except for the IDLE selection.
- grant_id retains the last grantee in IDLE, for debug.

Test Plan:
- NUM_REQ=4; all four valid with 3-beat packets (last on beat 3), fifo_full=0 → FIFO receives ids 0,0,0,1,1,1,2,2,2,3,3,3. Exactly one idle cycle between bursts; last bit set on every 3rd word.
- Only requester 2 valid, packet of 40 beats, MAX_BURST=16 → three grants of 16,16,8 beats. Last=1 only on word 40. No other id appears.
- fifo_full forced high for 5 cycles mid-burst of requester 1 → fifo_wr_en=0 and req_ready=0 for those 5 cycles. Burst resumes with the next unwritten data byte; total beat count unchanged.
- Requesters 0 and 3 valid, rr pointer at 1 after a grant to 0 → next grant goes to 3, then 0. Confirms wrap-around.
- arb_en dropped mid-burst of requester 1 → burst completes through last, busy falls. No further grant until arb_en=1.
- rst asserted on beat 2 of a 5-beat burst, wired to async_fifo_fwft (ADDR_WIDTH=4, RESERVE=3) with rd_clk 50 MHz and wr_clk 80 MHz → busy=0 and fifo_wr_en=0 from the next cycle. After release, 1000 random packets from 4 sources are read back in order per id, with scoreboard match.
